transfer_scheduler: RTL

Arbitrates the shared transmit counter between NREQ requesters and sequences its transfer-permission line. Each granted requester receives a burst of exactly `len` cycles of `trfr_prm` high, then a mandatory low gap so the counter clears to 0 before the next burst. The block sits between the requesting channels and the transceiver counter. It monitors the counter's value to flag loss of synchronisation.

---
 rtl/transfer_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/transfer_scheduler.sv
// Round-robin owner of the shared transmit counter: grants fixed-length trfr_prm
// bursts, forces a low gap between them, and flags counter values that drift.
module transfer_scheduler #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 16,
  parameter int GAP   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic [31:0]           cnt_in,
  output logic                  trfr_prm,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  abort,
  output logic                  busy,
  output logic                  sync_err,
  output logic [1:0]            state_dbg
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int GAP_W = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    GAP_ST = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      expected;
  logic [GAP_W-1:0] gap_cnt;

  logic [LEN_W-1:0] len_arr [NREQ];
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] nxt_ptr;
  logic [PTR_W:0]   sum;

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len[g*LEN_W +: LEN_W];
  end

  // Search starts at the pointer and wraps; the extra sum bit absorbs the wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
      if (!found && req[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = sum[PTR_W-1:0];
      end
    end
  end

  assign nxt_ptr   = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      remaining <= '0;
      expected  <= '0;
      gap_cnt   <= '0;
      trfr_prm  <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      abort     <= 1'b0;
      busy      <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      done  <= '0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            ptr <= nxt_ptr;
            if (len_arr[win] != '0) begin
              gnt       <= NREQ'(1) << win;
              trfr_prm  <= 1'b1;
              remaining <= len_arr[win];
              expected  <= '0;
              owner     <= win;
              busy      <= 1'b1;
              state     <= XFER;
            end else begin
              done[win] <= 1'b1;
            end
          end
        end
        XFER: begin
          if (cnt_in != expected) sync_err <= 1'b1;
          expected  <= expected + 32'd1;
          remaining <= remaining - 1'b1;
          // A dropped request wins over a burst that would have ended anyway.
          if (!req[owner] || remaining == LEN_W'(1)) begin
            trfr_prm <= 1'b0;
            gnt      <= '0;
            gap_cnt  <= GAP_W'(GAP);
            state    <= GAP_ST;
            if (!req[owner]) abort <= 1'b1;
            else             done[owner] <= 1'b1;
          end
        end
        GAP_ST: begin
          if (gap_cnt == GAP_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
